// File: rtl/minmax_pkg.sv
// Shared types and the compare primitive for the min/max reduction tree.
package minmax_pkg;

    typedef enum logic {MM_MIN = 1'b0, MM_MAX = 1'b1} mm_mode_e;

    localparam int unsigned MM_DEFAULT_WIDTH = 8;
    // Operands are extended to this width before comparing; lane words must not exceed it.
    localparam int unsigned MM_CMP_W = 64;

    // Returns 1 when b strictly beats a; equal values keep a (the lower lane).
    function automatic logic mm_sel(
        input logic [MM_CMP_W-1:0] a,
        input logic [MM_CMP_W-1:0] b,
        input mm_mode_e            mode,
        input logic                signed_cmp
    );
        logic b_lt;
        logic b_gt;
        if (signed_cmp) begin
            b_lt = ($signed(b) < $signed(a));
            b_gt = ($signed(b) > $signed(a));
        end else begin
            b_lt = (b < a);
            b_gt = (b > a);
        end
        return (mode == MM_MAX) ? b_gt : b_lt;
    endfunction

endpackage

// File: rtl/minmax_cmp2.sv
// Combinational two-input min/max node; optional lane index under MINMAX_INDEX_EN.
module minmax_cmp2 import minmax_pkg::*; #(
    parameter int unsigned WIDTH  = MM_DEFAULT_WIDTH,
`ifdef MINMAX_INDEX_EN
    parameter int unsigned IDXW   = 2,
`endif
    parameter bit          SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef MINMAX_INDEX_EN
    input  logic [IDXW-1:0]  a_idx_i,
    input  logic [IDXW-1:0]  b_idx_i,
    output logic [IDXW-1:0]  y_idx_o,
`endif
    input  logic             mode_i,
    output logic [WIDTH-1:0] y_o
);

    logic [MM_CMP_W-1:0] a_x;
    logic [MM_CMP_W-1:0] b_x;
    logic                b_wins;

    always_comb begin
        if (SIGNED) begin
            a_x = MM_CMP_W'($signed(a_i));
            b_x = MM_CMP_W'($signed(b_i));
        end else begin
            a_x = MM_CMP_W'(a_i);
            b_x = MM_CMP_W'(b_i);
        end
        b_wins = mm_sel(a_x, b_x, mm_mode_e'(mode_i), SIGNED);
        y_o    = b_wins ? b_i : a_i;
`ifdef MINMAX_INDEX_EN
        y_idx_o = b_wins ? b_idx_i : a_idx_i;
`endif
    end

endmodule

// File: rtl/min_max_tree_pipe.sv
// Pipelined NUM_IN-lane min/max reduction, one register row per tree level.
// Define MINMAX_INDEX_EN to carry lane indices and expose out_index.
module min_max_tree_pipe import minmax_pkg::*; #(
    parameter int unsigned WIDTH  = MM_DEFAULT_WIDTH,
    parameter int unsigned NUM_IN = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef MINMAX_INDEX_EN
    output logic [$clog2(NUM_IN)-1:0] out_index,
`endif
    output logic [WIDTH-1:0]          out_data
);

    localparam int unsigned LEVELS = $clog2(NUM_IN);
    localparam int unsigned NODES  = NUM_IN - 1;

    // All tree nodes packed flat: level k occupies nodes [NUM_IN-(NUM_IN>>k) +: NUM_IN>>(k+1)].
    logic [NODES*WIDTH-1:0]  tree_d;
    logic [NODES*WIDTH-1:0]  tree_q;
`ifdef MINMAX_INDEX_EN
    logic [NODES*LEVELS-1:0] idx_d;
    logic [NODES*LEVELS-1:0] idx_q;
`endif
    logic [LEVELS-1:0]       valid_d;
    logic [LEVELS-1:0]       valid_q;
    logic [LEVELS-1:0]       mode_src;
    logic                    stall;
    logic                    advance;

    always_comb begin
        stall    = valid_q[LEVELS-1] & ~out_ready;
        advance  = ~stall;
        in_ready = ~stall;
    end

    always_comb begin
        valid_d    = '0;
        valid_d[0] = in_valid;
        for (int unsigned k = 1; k < LEVELS; k++) begin
            valid_d[k] = valid_q[k-1];
        end
    end

    // mode_src[k] is the mode of the beat feeding level k's comparators this cycle.
    if (LEVELS > 1) begin : g_mode
        logic [LEVELS-2:0] mode_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q <= '0;
            end else if (advance) begin
                mode_q <= mode_src[LEVELS-2:0];
            end
        end
        assign mode_src = {mode_q, in_mode};
    end else begin : g_mode1
        assign mode_src = in_mode;
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned CNT = NUM_IN >> (k + 1);
        localparam int unsigned DST = NUM_IN - (NUM_IN >> k);
        localparam int unsigned SRC = (k == 0) ? 0 : NUM_IN - ((2 * NUM_IN) >> k);

        for (genvar n = 0; n < CNT; n++) begin : g_node
            logic [WIDTH-1:0]  a;
            logic [WIDTH-1:0]  b;
`ifdef MINMAX_INDEX_EN
            logic [LEVELS-1:0] a_idx;
            logic [LEVELS-1:0] b_idx;
`endif
            if (k == 0) begin : g_leaf
                assign a = in_data[(2*n)*WIDTH +: WIDTH];
                assign b = in_data[(2*n+1)*WIDTH +: WIDTH];
`ifdef MINMAX_INDEX_EN
                assign a_idx = LEVELS'(2*n);
                assign b_idx = LEVELS'(2*n+1);
`endif
            end else begin : g_inner
                assign a = tree_q[(SRC+2*n)*WIDTH +: WIDTH];
                assign b = tree_q[(SRC+2*n+1)*WIDTH +: WIDTH];
`ifdef MINMAX_INDEX_EN
                assign a_idx = idx_q[(SRC+2*n)*LEVELS +: LEVELS];
                assign b_idx = idx_q[(SRC+2*n+1)*LEVELS +: LEVELS];
`endif
            end

            minmax_cmp2 #(
                .WIDTH   (WIDTH),
`ifdef MINMAX_INDEX_EN
                .IDXW    (LEVELS),
`endif
                .SIGNED  (SIGNED)
            ) u_cmp (
                .a_i     (a),
                .b_i     (b),
`ifdef MINMAX_INDEX_EN
                .a_idx_i (a_idx),
                .b_idx_i (b_idx),
                .y_idx_o (idx_d[(DST+n)*LEVELS +: LEVELS]),
`endif
                .mode_i  (mode_src[k]),
                .y_o     (tree_d[(DST+n)*WIDTH +: WIDTH])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tree_q  <= '0;
`ifdef MINMAX_INDEX_EN
            idx_q   <= '0;
`endif
        end else if (advance) begin
            valid_q <= valid_d;
            tree_q  <= tree_d;
`ifdef MINMAX_INDEX_EN
            idx_q   <= idx_d;
`endif
        end
    end

    always_comb begin
        out_valid = valid_q[LEVELS-1];
        out_data  = tree_q[(NODES-1)*WIDTH +: WIDTH];
`ifdef MINMAX_INDEX_EN
        out_index = idx_q[(NODES-1)*LEVELS +: LEVELS];
`endif
    end

endmodule
